// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx
//   Receives the serial stream from the 8-bit parallel-load/serial-out register,
//   assembles WIDTH-bit words and presents them on a latched parallel bus with a
//   valid/ack handshake. The shift register and the output latch are separate, so
//   a held word survives reception of the next frame.
//
// Optional feature: define PARITY_CHECK_EN to expect one even-parity bit after the
//   WIDTH data bits (frame length WIDTH+1). Undefined: frame length WIDTH, perr = 0.
//
// Parameters
//   WIDTH      data bits per frame (>= 2)
//   MSB_FIRST  1: first received bit lands in q[WIDTH-1]; 0: first bit lands in q[0]
//
// Ports
//   cp        in   clock, all state updates on posedge
//   mr        in   synchronous active-high reset
//   start     in   begin a frame (seen in IDLE only)
//   shift_en  in   sample ds this cycle (SHIFT only)
//   ds        in   serial data
//   ack       in   consumer has taken q; clears valid
//   q         out  latched parallel word
//   valid     out  q holds an unacknowledged word
//   busy      out  high while in SHIFT
//   overrun   out  sticky: a word was overwritten unacknowledged
//   perr      out  parity error on the word in q
module serial_to_parallel_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             cp,
    input  logic             mr,
    input  logic             start,
    input  logic             shift_en,
    input  logic             ds,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             perr
);

    localparam int CW = $clog2(WIDTH + 2);
`ifdef PARITY_CHECK_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             xfer;

    // shreg with the current ds bit folded in
    assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], ds} : {ds, shreg[WIDTH-1:1]};

`ifdef PARITY_CHECK_EN
    // Last sample is the parity bit: data is already complete in shreg.
    logic par_err;
    assign word    = shreg;
    assign par_err = (^shreg) ^ ds;
`else
    // Last sample is the final data bit: take it straight from ds.
    assign word    = shifted;
`endif

    always_comb begin
        state_n = state;
        count_n = count;
        shreg_n = shreg;
        busy    = 1'b0;
        xfer    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SHIFT;
                    count_n = '0;
                    shreg_n = '0;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (shift_en) begin
                    // parity bit (if any) is never shifted into shreg
                    if (count < CW'(WIDTH))
                        shreg_n = shifted;
                    if (count == CW'(NBITS - 1)) begin
                        xfer    = 1'b1;
                        state_n = IDLE;
                        count_n = '0;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge cp) begin
        if (mr) begin
            state <= IDLE;
            count <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            shreg <= shreg_n;
        end
    end

    // Output latch and handshake. A transfer wins over ack: the new word is
    // valid regardless, and overrun only sets if the old word was never taken.
    always_ff @(posedge cp) begin
        if (mr) begin
            q       <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (xfer) begin
            q     <= word;
            valid <= 1'b1;
            if (valid && !ack)
                overrun <= 1'b1;
        end else if (ack) begin
            valid <= 1'b0;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge cp) begin
        if (mr)
            perr <= 1'b0;
        else if (xfer)
            perr <= par_err;
    end
`else
    assign perr = 1'b0;
`endif

endmodule
